// File: rtl/soc_rst_seq.sv
// Reset sequencer: holds all channels in reset, releases them staggered, then times a RUN phase.
// Optional watchdog on the RUN phase is compiled in with `define SOC_RST_SEQ_WDT_EN.
module soc_rst_seq #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_CYC    = 10,
  parameter int unsigned STAGGER_CYC = 4,
  parameter int unsigned TIMEOUT_CYC = 25,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              soft_rst_req,
  input  logic              halt_i,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              done,
  output logic              timeout,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    STOP    = 2'd3
  } state_t;

  localparam int unsigned LAST_REL = STAGGER_CYC * (NUM_CH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [NUM_CH-1:0]  ch_q, ch_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               wdt_hit;

`ifdef SOC_RST_SEQ_WDT_EN
  // Compared at 32 bits so a budget wider than CNT_W can never alias.
  assign wdt_hit = (32'(run_cnt_q) == TIMEOUT_CYC - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign wdt_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    run_cnt_d = run_cnt_q;
    ch_d      = ch_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    if (soft_rst_req) begin
      state_d   = HOLD;
      phase_d   = '0;
      run_cnt_d = '0;
      ch_d      = '0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (32'(phase_q) == HOLD_CYC - 1) begin
            state_d = RELEASE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        RELEASE: begin
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(phase_q) >= STAGGER_CYC * k) ch_d[k] = 1'b1;
          end
          // The last channel's release edge is also the edge into RUN.
          if (32'(phase_q) == LAST_REL) begin
            state_d = RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        RUN: begin
          if (halt_i) begin
            state_d = STOP;
            done_d  = 1'b1;
          end else if (wdt_hit) begin
            state_d   = STOP;
            timeout_d = 1'b1;
          end else if (run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        STOP: begin
        end
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= HOLD;
      phase_q   <= '0;
      run_cnt_q <= '0;
      ch_q      <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      run_cnt_q <= run_cnt_d;
      ch_q      <= ch_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign ch_rst_n = ch_q;
  assign run_cnt  = run_cnt_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Bench for soc_rst_seq: two configurations checked every cycle against an elapsed-time model.
module tb_soc_rst_seq;
`ifdef SOC_RST_SEQ_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] soft_req = '0;
  logic [1:0] halt = '0;

  logic [1:0]  a_ch;
  logic [15:0] a_cnt;
  logic        a_done, a_to;
  logic [1:0]  a_st;
  logic [3:0]  b_ch;
  logic [3:0]  b_cnt;
  logic        b_done, b_to;
  logic [1:0]  b_st;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  soc_rst_seq dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .soft_rst_req(soft_req[0]), .halt_i(halt[0]),
    .ch_rst_n(a_ch), .run_cnt(a_cnt), .done(a_done), .timeout(a_to), .state_o(a_st)
  );

  soc_rst_seq #(.NUM_CH(4), .HOLD_CYC(3), .STAGGER_CYC(0), .TIMEOUT_CYC(16), .CNT_W(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .soft_rst_req(soft_req[1]), .halt_i(halt[1]),
    .ch_rst_n(b_ch), .run_cnt(b_cnt), .done(b_done), .timeout(b_to), .state_o(b_st)
  );

  // Model: everything follows from the number of edges e since the sequence was cleared.
  int P_N[2]   = '{2, 4};
  int P_H[2]   = '{10, 3};
  int P_S[2]   = '{4, 0};
  int P_T[2]   = '{25, 16};
  int P_MAX[2] = '{65535, 15};
  int m_e[2]   = '{0, 0};
  int m_frz[2] = '{0, 0};
  bit m_stop[2] = '{0, 0};
  bit m_done[2] = '{0, 0};
  bit m_to[2]   = '{0, 0};

  function automatic int run_start(int i);
    return P_H[i] + 1 + P_S[i] * (P_N[i] - 1);
  endfunction

  function automatic int m_state(int i);
    if (m_stop[i]) return 3;
    if (m_e[i] >= run_start(i)) return 2;
    if (m_e[i] >= P_H[i]) return 1;
    return 0;
  endfunction

  function automatic int m_cnt(int i);
    int c;
    if (m_stop[i]) return m_frz[i];
    if (m_e[i] < run_start(i)) return 0;
    c = m_e[i] - run_start(i);
    return (c > P_MAX[i]) ? P_MAX[i] : c;
  endfunction

  function automatic int m_ch(int i);
    int v = 0;
    if (m_stop[i]) return (1 << P_N[i]) - 1;
    for (int k = 0; k < P_N[i]; k++)
      if (m_e[i] >= P_H[i] + 1 + P_S[i] * k) v |= (1 << k);
    return v;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    for (int i = 0; i < 2; i++) begin
      if (sys_rst) begin
        m_e[i] = 0; m_stop[i] = 0; m_done[i] = 0; m_to[i] = 0; m_frz[i] = 0;
      end else begin
        bit in_run;
        int c;
        in_run = !m_stop[i] && (m_e[i] >= run_start(i));
        c = m_cnt(i);
        if (soft_req[i]) begin
          m_e[i] = 0; m_stop[i] = 0; m_done[i] = 0; m_to[i] = 0; m_frz[i] = 0;
        end else begin
          if (in_run && halt[i]) begin
            m_stop[i] = 1; m_done[i] = 1; m_frz[i] = c;
          end else if (WDT && in_run && c == P_T[i] - 1) begin
            m_stop[i] = 1; m_to[i] = 1; m_frz[i] = c;
          end
          m_e[i] = m_e[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      #2;
      if (!sys_rst) begin
        chk("A state", int'(a_st), m_state(0));
        chk("A ch", int'(a_ch), m_ch(0));
        chk("A cnt", int'(a_cnt), m_cnt(0));
        chk("A done", int'(a_done), int'(m_done[0]));
        chk("A timeout", int'(a_to), int'(m_to[0]));
        chk("B state", int'(b_st), m_state(1));
        chk("B ch", int'(b_ch), m_ch(1));
        chk("B cnt", int'(b_cnt), m_cnt(1));
        chk("B done", int'(b_done), int'(m_done[1]));
        chk("B timeout", int'(b_to), int'(m_to[1]));
      end
    end
  end

  initial begin
    tick(10);
    chk("rst A ch", int'(a_ch), 0);
    chk("rst A state", int'(a_st), 0);
    chk("rst A cnt", int'(a_cnt), 0);
    chk("rst B ch", int'(b_ch), 0);
    sys_rst = 1'b0;

    tick(10);
    chk("hold A ch", int'(a_ch), 0);
    chk("hold A state", int'(a_st), 1);
    tick(1);
    chk("rel A ch0", int'(a_ch), 1);
    tick(3);
    chk("rel A ch1 low", int'(a_ch), 1);
    tick(1);
    chk("rel A ch1", int'(a_ch), 3);
    chk("run A state", int'(a_st), 2);
    chk("run A cnt0", int'(a_cnt), 0);
    tick(24);
    chk("run A cnt24", int'(a_cnt), 24);
    tick(1);
    if (WDT) begin
      chk("wdt A state", int'(a_st), 3);
      chk("wdt A timeout", int'(a_to), 1);
      chk("wdt A cnt", int'(a_cnt), 24);
      chk("wdt B state", int'(b_st), 3);
      chk("wdt B cnt", int'(b_cnt), 15);
    end else begin
      chk("nowdt A state", int'(a_st), 2);
      chk("nowdt A cnt", int'(a_cnt), 25);
      chk("nowdt B state", int'(b_st), 2);
      chk("nowdt B cnt sat", int'(b_cnt), 15);
      chk("nowdt B timeout", int'(b_to), 0);
    end

    soft_req[0] = 1'b1; tick(1); soft_req[0] = 1'b0;
    chk("soft A ch", int'(a_ch), 0);
    chk("soft A state", int'(a_st), 0);
    chk("soft A timeout", int'(a_to), 0);
    chk("soft A cnt", int'(a_cnt), 0);
    tick(11);
    chk("soft A ch0", int'(a_ch), 1);
    soft_req[0] = 1'b1; tick(1); soft_req[0] = 1'b0;
    chk("midrel A ch", int'(a_ch), 0);
    chk("midrel A state", int'(a_st), 0);
    tick(15);
    chk("rerun A ch", int'(a_ch), 3);
    chk("rerun A state", int'(a_st), 2);
    tick(5);
    chk("halt5 A cnt pre", int'(a_cnt), 5);
    halt[0] = 1'b1; tick(1);
    chk("halt5 A state", int'(a_st), 3);
    chk("halt5 A done", int'(a_done), 1);
    chk("halt5 A timeout", int'(a_to), 0);
    chk("halt5 A cnt", int'(a_cnt), 5);
    tick(2); halt[0] = 1'b0; tick(1);
    chk("stop A cnt", int'(a_cnt), 5);
    chk("stop A ch", int'(a_ch), 3);

    soft_req[0] = 1'b1; tick(1); soft_req[0] = 1'b0;
    tick(39);
    chk("tie A cnt", int'(a_cnt), 24);
    halt[0] = 1'b1; tick(1); halt[0] = 1'b0;
    chk("tie A done", int'(a_done), 1);
    chk("tie A timeout", int'(a_to), 0);
    chk("tie A state", int'(a_st), 3);

    soft_req[1] = 1'b1; tick(1); soft_req[1] = 1'b0;
    tick(3);
    chk("B pre ch", int'(b_ch), 0);
    chk("B pre state", int'(b_st), 1);
    tick(1);
    chk("B all ch", int'(b_ch), 15);
    chk("B run state", int'(b_st), 2);
    tick(3);
    @(posedge sys_clk);
    #3 sys_rst = 1'b1;
    #1;
    chk("async B ch", int'(b_ch), 0);
    chk("async B state", int'(b_st), 0);
    chk("async A ch", int'(a_ch), 0);
    chk("async A done", int'(a_done), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick(6);
    chk("post B ch", int'(b_ch), 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_rst_seq.md
SOC_RST_SEQ -- requirements
Module: soc_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of downstream reset channels, range 1..8.
REQ-002 SHALL have parameter HOLD_CYC, default 10: cycles all channels stay in reset after sequencer reset or soft reset; must be at least 1.
REQ-003 SHALL have parameter STAGGER_CYC, default 4: cycles between successive channel releases; 0 means all channels release together.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 25: RUN-state cycle budget before timeout; must be at least 1.
REQ-005 SHALL have parameter CNT_W, default 16: width of all internal counters and run_cnt.
REQ-006 SHALL have port sys_clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port soft_rst_req, input, 1 bit: single-cycle request to re-run the full reset sequence.
REQ-009 SHALL have port halt_i, input, 1 bit: downstream core reports program completion; level-sensitive.
REQ-010 SHALL have port ch_rst_n, output, NUM_CH bits: active-low resets, one per downstream block.
REQ-011 SHALL have port run_cnt, output, CNT_W bits: cycles spent in RUN.
REQ-012 SHALL have port done, output, 1 bit: sticky, set when halt_i is seen in RUN.
REQ-013 SHALL have port timeout, output, 1 bit: sticky, set when the watchdog expires.
REQ-014 SHALL have port state_o, output, 2 bits: current FSM state encoding.

Function
REQ-015 SHALL implement FSM states with encodings HOLD=0, RELEASE=1, RUN=2, STOP=3.
REQ-016 HOLD SHALL hold ch_rst_n all zero and count HOLD_CYC cycles, then enter RELEASE.
REQ-017 RELEASE SHALL drive channel k high STAGGER_CYC*k cycles after RELEASE entry, with channel 0 going high in the first RELEASE cycle.
REQ-018 RELEASE SHALL enter RUN in the cycle after the last channel (NUM_CH-1) is released.
REQ-019 Once released in a sequence, a channel SHALL stay high until the next HOLD.
REQ-020 RUN SHALL increment run_cnt by 1 every cycle, saturating at all-ones with no wrap.
REQ-021 When halt_i is 1 in RUN, the FSM SHALL enter STOP next cycle and set done; run_cnt freezes.
REQ-022 When run_cnt reaches TIMEOUT_CYC-1 in RUN without halt_i, the FSM SHALL enter STOP next cycle and set timeout.
REQ-023 If halt_i and the timeout condition occur in the same cycle, halt_i SHALL win: done=1, timeout=0.
REQ-024 STOP SHALL keep ch_rst_n all ones and SHALL ignore halt_i.
REQ-025 soft_rst_req=1 in any state SHALL cause the next state to be HOLD.
REQ-026 On entering HOLD via soft_rst_req, the block SHALL clear ch_rst_n, run_cnt, done and timeout, and restart the hold count.
REQ-027 soft_rst_req SHALL have priority over halt_i and over the timeout condition.
REQ-028 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 While sys_rst=1, the block SHALL force asynchronously: state HOLD, ch_rst_n all zero, run_cnt 0, done 0, timeout 0, all internal counters 0.
REQ-030 After sys_rst deasserts, the hold count SHALL start on the first sys_clk rising edge.
REQ-031 Asserting sys_rst mid-RELEASE or mid-RUN SHALL immediately drive every channel low.

Configuration
REQ-032 SHALL support macro SOC_RST_SEQ_WDT_EN, which compiles the watchdog in or out.
REQ-033 With SOC_RST_SEQ_WDT_EN defined, the watchdog behaviour of REQ-022/023 SHALL apply.
REQ-034 Without SOC_RST_SEQ_WDT_EN, timeout SHALL be constant 0, RUN SHALL leave only on halt_i or soft_rst_req, TIMEOUT_CYC SHALL be unused, and run_cnt saturation still applies.

Verification
REQ-035 Defaults, sys_rst high 10 cycles then low, halt_i=0, WDT enabled -> ch_rst_n[0] rises 11 cycles after release, ch_rst_n[1] 4 cycles later, RUN lasts 25 cycles, then timeout=1, state_o=3, run_cnt=24.
REQ-036 Same setup, halt_i pulsed on RUN cycle 5 -> done=1, timeout=0, run_cnt frozen at 5, channels stay high.
REQ-037 halt_i asserted on the same cycle run_cnt=24 -> done=1, timeout=0.
REQ-038 soft_rst_req pulsed in STOP, and again mid-RELEASE after channel 0 is released -> all channels drop next cycle, flags cleared, full HOLD/stagger sequence repeats.
REQ-039 NUM_CH=4, STAGGER_CYC=0 -> all four channels rise in the same cycle; sys_rst asserted asynchronously mid-RUN (between clock edges) -> ch_rst_n=0000 with no clock edge.
REQ-040 SOC_RST_SEQ_WDT_EN undefined, CNT_W=4, halt_i=0 -> timeout stays 0, run_cnt saturates at 15, state_o stays 2.
